// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue parameters and the counter-update helper used by the queue.
// Depth and word widths default from here so the core can retune them in one place.
package fetch_queue_pkg;

  localparam int FQ_DEPTH  = 4;
  localparam int FQ_INST_W = 16;
  localparam int FQ_ADDR_W = 16;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

  // Classify the occupancy update from this cycle's push/pop pair.
  function automatic cnt_op_e cnt_op(input logic push, input logic pop);
    return cnt_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle of the fetch queue.
// The master side is the fetch/execute/decode environment, the slave side is the queue.
interface fetch_queue_if #(
  parameter int INST_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 3
);
  logic              v_i;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] origaddr_i;
  logic              flush_i;
  logic              stall_i;
  logic              full_o;
  logic              v_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] origaddr_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output v_i, inst_i, origaddr_i, flush_i, stall_i,
    input  full_o, v_o, inst_o, origaddr_o, count_o
  );

  modport slave (
    input  v_i, inst_i, origaddr_i, flush_i, stall_i,
    output full_o, v_o, inst_o, origaddr_o, count_o
  );
endinterface

// File: rtl/fetch_queue_chk.sv
// Pointer/occupancy consistency checker for the fetch queue.
// Occupancy must equal the pointer distance, with equal pointers meaning full or empty.
module fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic [PTR_W-1:0] rp,
  input logic [PTR_W-1:0] wp,
  input logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] dist_s;
  assign dist_s = wp - rp;

  ptr_invariant_a : assert property (@(posedge clk) disable iff (!rst)
    (cnt <= DEPTH_C) && (dist_s == cnt[PTR_W-1:0]));
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between fetch and decode: circular store of
// instruction/address pairs, oldest entry presented to decode, flushed on taken branch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int INST_W = FQ_INST_W,
  parameter int ADDR_W = FQ_ADDR_W
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [INST_W-1:0] inst_mem_r [DEPTH];
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [PTR_W-1:0]  rp_r;
  logic [PTR_W-1:0]  wp_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              full_s;
  logic              v_s;
  logic              push_s;
  logic              pop_s;

  // Handshake decode; push tests full before any same-cycle pop, so no push-through.
  always_comb begin
    full_s    = (cnt_r == DEPTH_C);
    v_s       = (cnt_r != '0) & ~fq.flush_i;
    push_s    = fq.v_i & ~full_s & ~fq.flush_i;
    pop_s     = v_s & ~fq.stall_i;
    cnt_nxt_s = cnt_r;
    case (cnt_op(push_s, pop_s))
      CNT_INC: cnt_nxt_s = cnt_r + CNT_W'(1);
      CNT_DEC: cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  assign fq.full_o     = full_s;
  assign fq.v_o        = v_s;
  assign fq.count_o    = cnt_r;
  assign fq.inst_o     = (cnt_r == '0) ? '0 : inst_mem_r[rp_r];
  assign fq.origaddr_o = (cnt_r == '0) ? '0 : addr_mem_r[rp_r];

  // Pointer and occupancy state; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_r  <= '0;
      wp_r  <= '0;
      cnt_r <= '0;
    end else if (fq.flush_i) begin
      rp_r  <= '0;
      wp_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (push_s) wp_r <= wp_r + PTR_W'(1);
      if (pop_s)  rp_r <= rp_r + PTR_W'(1);
      cnt_r <= cnt_nxt_s;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wp_r] <= fq.inst_i;
      addr_mem_r[wp_r] <= fq.origaddr_i;
    end
  end

  fetch_queue_chk #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk (clk),
    .rst (rst),
    .rp  (rp_r),
    .wp  (wp_r),
    .cnt (cnt_r)
  );
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between instruction fetch/instruction memory and the decode stage.
- Captures each valid fetched instruction with its original address and presents the oldest one to decode.
- Absorbs decode stalls so fetch can keep running until the buffer is full.
- Flushes all entries on a taken branch, so decode never sees wrong-path instructions.

Parameters:
DEPTH, 4, number of buffered entries; power of two, minimum 2
INST_W, 16, instruction word width
ADDR_W, 16, instruction address width

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset; 0 = reset, 1 = run
v_i  input  1  fetch presents a valid instruction this cycle
inst_i  input  INST_W  instruction word from instruction memory
origaddr_i  input  ADDR_W  address of inst_i
flush_i  input  1  taken branch from execute; discard all contents
stall_i  input  1  decode cannot consume this cycle
full_o  output  1  buffer full; fetch must hold its address
v_o  output  1  head entry valid towards decode
inst_o  output  INST_W  head instruction
origaddr_o  output  ADDR_W  head instruction address
count_o  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- Circular buffer with read pointer rp, write pointer wp (clog2(DEPTH) bits each, natural wrap) and occupancy counter cnt (0..DEPTH).
- Reset (rst=0, asynchronous):
  - rp, wp and cnt go to 0.
  - full_o=0, v_o=0, count_o=0.
  - inst_o and origaddr_o read 0; storage contents are don't-care.
- Combinational outputs:
  - full_o = (cnt==DEPTH).
  - v_o = (cnt!=0) & ~flush_i.
  - inst_o/origaddr_o = entry[rp]; forced to 0 when cnt==0.
  - count_o = cnt.
- push = v_i & ~full_o & ~flush_i. On push, write entry[wp] and advance wp.
- pop = v_o & ~stall_i. On pop, advance rp.
- cnt next value:
  - +1 on push only.
  - -1 on pop only.
  - unchanged when push and pop occur together, including at cnt==DEPTH-1 and cnt==1.
- Full:
  - v_i is ignored when full_o=1.
  - There is no push-through when full, even if a pop happens the same cycle.
  - full_o deasserts the cycle after a pop.
- Empty: no pass-through. An instruction pushed in cycle N first appears on v_o in cycle N+1, giving 1-cycle minimum latency.
- Flush (flush_i=1):
  - Next edge sets rp=wp=cnt=0.
  - The same-cycle push is discarded.
  - v_o is low during the flush cycle, so no pop occurs.
  - Flush takes priority over stall_i and v_i.
- Pointer wrap: after DEPTH pushes, wp returns to 0. FIFO order must be preserved across the wrap.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Releasing reset gives the empty state; the first push can be taken on the first edge with rst=1.
- Invariant: cnt == (wp - rp) mod DEPTH, except when cnt==DEPTH, where wp==rp. Verification checks this with an assertion.

Decomposition:
- INST_W and ADDR_W defaults come from the shared parameter header alongside the existing core parameters.
- The DEPTH default also lives there, as a fetch-queue depth constant.
- No sub-module: storage array, pointers and counter live in one module.
- Integrate in core between the IF/IM outputs and the ID inputs:
  - stall_idif drives stall_i.
  - full_o is ORed into the fetch hold.
  - The execute branch signal drives flush_i.

Test Plan:
- Reset/idle: hold rst=0 then release, v_i=0 for 5 cycles -> v_o=0, full_o=0, count_o=0 throughout; assert rst=0 mid-run with cnt=3 -> count_o=0 and v_o=0 immediately, before the next edge.
- Stream, no stall: push 0x1111@0x0000, 0x2222@0x0002, 0x3333@0x0004 on consecutive cycles, stall_i=0 -> decode sees the same order, each one cycle after its push; count_o stays at 1.
- Fill and hold: stall_i=1, push 5 instructions 0xA000..0xA004 -> first 4 accepted, full_o=1 after the 4th, 0xA004 ignored; release stall -> 0xA000..0xA003 in order, full_o drops one cycle after the first pop.
- Simultaneous push/pop at full-1: cnt=3, v_i=1 and stall_i=0 -> count_o stays 3, and the head advances to the next entry.
- Flush: cnt=3 with v_i=1 (0xBEEF) and flush_i=1 -> v_o=0 that cycle; next cycle count_o=0 and v_o=0, and 0xBEEF never appears.
- Wrap-around: 10 push/pop cycles with random stalls, words 0x0001..0x000A -> outputs match a reference model in order, and the pointer invariant holds every cycle.
